xilinx_fifo_sync_generic: RTL and testbench

- Single-clock, fully parametrised behavioural FIFO that replaces dual-clock primitive wrappers wherever read and write share one clock domain.
- Depth and width are free parameters rather than being bound to 18Kb/36Kb macro geometry.
- Provides an exact occupancy count and runtime-independent almost thresholds.
- Supports standard mode (1-cycle read latency) and FWFT mode, selected by parameter; memory is inferred (BRAM or LUTRAM chosen by synthesis).

---
 rtl/xilinx_fifo_sync_generic.sv | 157 +++++++++++++++
 tb/tb_xilinx_fifo_sync_generic.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xilinx_fifo_sync_generic.sv
// Single-clock behavioural FIFO with free depth/width, an exact occupancy
// count and fixed almost-empty/almost-full thresholds. The memory is inferred,
// so synthesis chooses block RAM or distributed RAM.
//
// Modes (FIRST_WORD_FALL_THROUGH):
//   "FALSE" : standard mode. A read accepted at an edge presents its word on DO
//             after that edge. DO holds that word until the next accepted read.
//   "TRUE"  : FWFT mode. DO is an output register that holds the head word.
//             EMPTY is low while that register is valid. RDEN pops the head.
//
// Ports:
//   CLK          rising-edge clock
//   RST          asynchronous, active-high reset (memory contents kept)
//   DI/WREN      write data / write request (accepted iff !FULL)
//   RDEN         read request (standard) or pop request (FWFT), accepted iff !EMPTY
//   DO           read data / head word
//   EMPTY, FULL  registered status flags
//   ALMOSTEMPTY  COUNT <= ALMOST_EMPTY_OFFSET
//   ALMOSTFULL   COUNT >= FIFO_DEPTH - ALMOST_FULL_OFFSET
//   COUNT        words held, including the FWFT output register
//   RDERR/WRERR  one-cycle pulse after a rejected read/write request
module xilinx_fifo_sync_generic #(
  parameter int    DATA_WIDTH              = 8,
  parameter int    FIFO_DEPTH              = 512,
  parameter int    ALMOST_EMPTY_OFFSET     = 16,
  parameter int    ALMOST_FULL_OFFSET      = 16,
  parameter string FIRST_WORD_FALL_THROUGH = "FALSE"
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [DATA_WIDTH-1:0]       DI,
  input  logic                        WREN,
  input  logic                        RDEN,
  output logic [DATA_WIDTH-1:0]       DO,
  output logic                        EMPTY,
  output logic                        FULL,
  output logic                        ALMOSTEMPTY,
  output logic                        ALMOSTFULL,
  output logic [$clog2(FIFO_DEPTH):0] COUNT,
  output logic                        RDERR,
  output logic                        WRERR
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam bit FWFT = (FIRST_WORD_FALL_THROUGH == "TRUE");

  if ((FIFO_DEPTH < 4) || (FIFO_DEPTH > 65536) ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("xilinx_fifo_sync_generic: FIFO_DEPTH must be a power of two in 4..65536");
  end
  if ((DATA_WIDTH < 1) || (DATA_WIDTH > 1024)) begin : g_bad_width
    $error("xilinx_fifo_sync_generic: DATA_WIDTH must be in 1..1024");
  end
  if ((ALMOST_EMPTY_OFFSET < 1) || (ALMOST_EMPTY_OFFSET > FIFO_DEPTH - 2)) begin : g_bad_ae
    $error("xilinx_fifo_sync_generic: ALMOST_EMPTY_OFFSET must be in 1..FIFO_DEPTH-2");
  end
  if ((ALMOST_FULL_OFFSET < 1) || (ALMOST_FULL_OFFSET > FIFO_DEPTH - 2)) begin : g_bad_af
    $error("xilinx_fifo_sync_generic: ALMOST_FULL_OFFSET must be in 1..FIFO_DEPTH-2");
  end
  if ((FIRST_WORD_FALL_THROUGH != "TRUE") && (FIRST_WORD_FALL_THROUGH != "FALSE")) begin : g_bad_mode
    $error("xilinx_fifo_sync_generic: FIRST_WORD_FALL_THROUGH must be \"TRUE\" or \"FALSE\"");
  end

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q,  count_d;
  logic [DATA_WIDTH-1:0] do_q,     do_d;
  logic                  ov_q,     ov_d;
  logic                  empty_q,  empty_d;
  logic                  full_q,   full_d;
  logic                  ae_q,     ae_d;
  logic                  af_q,     af_d;
  logic                  rderr_q,  rderr_d;
  logic                  wrerr_q,  wrerr_d;

  logic                  wr_acc;
  logic                  rd_acc;
  logic                  load;
  logic [CW-1:0]         mem_cnt;

  always_comb begin
    // Requests are judged against the registered flags only.
    wr_acc  = WREN & ~full_q;
    rd_acc  = RDEN & ~empty_q;
    // Words still in memory. The FWFT output register is excluded.
    mem_cnt = count_q - CW'(ov_q);

    // In FWFT mode, memory feeds the output register whenever that register
    // is being popped or is empty. This keeps back-to-back pops at full rate.
    if (FWFT) begin
      load = (rd_acc | ~ov_q) & (mem_cnt != '0);
    end else begin
      load = rd_acc;
    end

    wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = load   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    do_d     = load   ? mem[rd_ptr_q]     : do_q;
    ov_d     = FWFT ? (load | (ov_q & ~rd_acc)) : 1'b0;

    count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
    empty_d  = FWFT ? ~ov_d : (count_d == '0);
    full_d   = (count_d == CW'(FIFO_DEPTH));
    ae_d     = (count_d <= CW'(ALMOST_EMPTY_OFFSET));
    af_d     = (count_d >= CW'(FIFO_DEPTH - ALMOST_FULL_OFFSET));
    rderr_d  = RDEN & empty_q;
    wrerr_d  = WREN & full_q;
  end

  // The memory has no reset, so synthesis can still infer RAM for it.
  always_ff @(posedge CLK) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= DI;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      do_q     <= '0;
      ov_q     <= 1'b0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= 1'b0;
      rderr_q  <= 1'b0;
      wrerr_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      do_q     <= do_d;
      ov_q     <= ov_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ae_q     <= ae_d;
      af_q     <= af_d;
      rderr_q  <= rderr_d;
      wrerr_q  <= wrerr_d;
    end
  end

  assign DO          = do_q;
  assign EMPTY       = empty_q;
  assign FULL        = full_q;
  assign ALMOSTEMPTY = ae_q;
  assign ALMOSTFULL  = af_q;
  assign COUNT       = count_q;
  assign RDERR       = rderr_q;
  assign WRERR       = wrerr_q;

endmodule

// File: tb/tb_xilinx_fifo_sync_generic.sv
// Directed bench for xilinx_fifo_sync_generic. It uses two 16-deep instances
// with almost offsets of 2: one in standard mode and one in FWFT mode.
module tb_xilinx_fifo_sync_generic;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic [7:0] s_di = '0;
  logic       s_wr = 1'b0;
  logic       s_rd = 1'b0;
  logic [7:0] s_do;
  logic       s_empty, s_full, s_ae, s_af, s_rderr, s_wrerr;
  logic [4:0] s_count;

  logic [7:0] f_di = '0;
  logic       f_wr = 1'b0;
  logic       f_rd = 1'b0;
  logic [7:0] f_do;
  logic       f_empty, f_full, f_ae, f_af, f_rderr, f_wrerr;
  logic [4:0] f_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  xilinx_fifo_sync_generic #(
    .DATA_WIDTH(8), .FIFO_DEPTH(16), .ALMOST_EMPTY_OFFSET(2),
    .ALMOST_FULL_OFFSET(2), .FIRST_WORD_FALL_THROUGH("FALSE")
  ) u_std (
    .CLK(clk), .RST(rst), .DI(s_di), .WREN(s_wr), .RDEN(s_rd), .DO(s_do),
    .EMPTY(s_empty), .FULL(s_full), .ALMOSTEMPTY(s_ae), .ALMOSTFULL(s_af),
    .COUNT(s_count), .RDERR(s_rderr), .WRERR(s_wrerr)
  );

  xilinx_fifo_sync_generic #(
    .DATA_WIDTH(8), .FIFO_DEPTH(16), .ALMOST_EMPTY_OFFSET(2),
    .ALMOST_FULL_OFFSET(2), .FIRST_WORD_FALL_THROUGH("TRUE")
  ) u_fwft (
    .CLK(clk), .RST(rst), .DI(f_di), .WREN(f_wr), .RDEN(f_rd), .DO(f_do),
    .EMPTY(f_empty), .FULL(f_full), .ALMOSTEMPTY(f_ae), .ALMOSTFULL(f_af),
    .COUNT(f_count), .RDERR(f_rderr), .WRERR(f_wrerr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after a rising edge. Outputs are sampled at that same
  // point, so they reflect the edge that just sampled the previous inputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] tail [5];
    tail = '{8'd12, 8'd13, 8'd14, 8'd15, 8'h55};

    // 1. Reset values. Checked during reset, and again after release.
    #2 rst = 1'b1;
    #1;
    chk("rst_async_count", 32'(s_count), 0);
    chk("rst_async_empty", 32'(s_empty), 1);
    #9 rst = 1'b0;
    tick();
    chk("rst_empty",  32'(s_empty), 1);
    chk("rst_ae",     32'(s_ae),    1);
    chk("rst_count",  32'(s_count), 0);
    chk("rst_do",     32'(s_do),    0);
    chk("rst_full",   32'(s_full),  0);
    chk("rst_af",     32'(s_af),    0);
    chk("rst_rderr",  32'(s_rderr), 0);
    chk("rst_wrerr",  32'(s_wrerr), 0);
    chk("rst_f_empty", 32'(f_empty), 1);
    chk("rst_f_do",    32'(f_do),    0);
    s_rd = 1'b1;
    tick();
    s_rd = 1'b0;
    chk("rderr_pulse",  32'(s_rderr), 1);
    chk("rderr_count",  32'(s_count), 0);
    tick();
    chk("rderr_clear",  32'(s_rderr), 0);

    // 2. Fill 0x00..0x0F and watch the flags change.
    s_wr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_di = 8'(i);
      tick();
      chk($sformatf("fill_count_%0d", i), 32'(s_count), 32'(i + 1));
      chk($sformatf("fill_ae_%0d", i),    32'(s_ae),    32'(i + 1 <= 2));
      chk($sformatf("fill_af_%0d", i),    32'(s_af),    32'(i + 1 >= 14));
      chk($sformatf("fill_full_%0d", i),  32'(s_full),  32'(i + 1 == 16));
    end
    s_di = 8'hEE;
    tick();
    s_wr = 1'b0;
    chk("ovf_wrerr", 32'(s_wrerr), 1);
    chk("ovf_count", 32'(s_count), 16);
    chk("ovf_full",  32'(s_full),  1);
    tick();
    chk("ovf_wrerr_clear", 32'(s_wrerr), 0);

    // 3. Drain in order.
    s_rd = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("drain_do_%0d", i),    32'(s_do),    32'(i));
      chk($sformatf("drain_count_%0d", i), 32'(s_count), 32'(15 - i));
    end
    s_rd = 1'b0;
    chk("drain_empty", 32'(s_empty), 1);
    tick();
    chk("drain_do_hold", 32'(s_do), 32'h0F);

    // Offset the pointers by one so that each round wraps in mid-stream.
    s_wr = 1'b1; s_di = 8'h99;
    tick();
    s_wr = 1'b0; s_rd = 1'b1;
    tick();
    s_rd = 1'b0;
    chk("offset_do", 32'(s_do), 32'h99);
    for (int r = 0; r < 3; r++) begin
      s_wr = 1'b1;
      for (int i = 0; i < 16; i++) begin
        s_di = 8'(8'h40 + r * 16 + i);
        tick();
      end
      s_wr = 1'b0;
      chk($sformatf("wrap_full_%0d", r), 32'(s_full), 1);
      s_rd = 1'b1;
      for (int i = 0; i < 16; i++) begin
        tick();
        chk($sformatf("wrap_do_%0d_%0d", r, i), 32'(s_do), 32'(8'h40 + r * 16 + i));
      end
      s_rd = 1'b0;
      chk($sformatf("wrap_empty_%0d", r), 32'(s_empty), 1);
    end

    // 4. Simultaneous read and write at full, mid-level and empty occupancy.
    s_wr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_di = 8'(i);
      tick();
    end
    s_rd = 1'b1; s_di = 8'h77;
    tick();
    s_wr = 1'b0;
    chk("full_rw_wrerr", 32'(s_wrerr), 1);
    chk("full_rw_count", 32'(s_count), 15);
    chk("full_rw_do",    32'(s_do),    0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("mid_do_%0d", i), 32'(s_do), 32'(i));
    end
    chk("mid_count", 32'(s_count), 5);
    s_wr = 1'b1; s_di = 8'h55;
    tick();
    s_wr = 1'b0;
    chk("mid_rw_count", 32'(s_count), 5);
    chk("mid_rw_do",    32'(s_do),    11);
    chk("mid_rw_wrerr", 32'(s_wrerr), 0);
    chk("mid_rw_rderr", 32'(s_rderr), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("tail_do_%0d", i), 32'(s_do), 32'(tail[i]));
    end
    s_rd = 1'b0;
    chk("tail_empty", 32'(s_empty), 1);
    chk("tail_count", 32'(s_count), 0);
    s_wr = 1'b1; s_rd = 1'b1; s_di = 8'h3C;
    tick();
    s_wr = 1'b0; s_rd = 1'b0;
    chk("empty_rw_rderr", 32'(s_rderr), 1);
    chk("empty_rw_count", 32'(s_count), 1);
    chk("empty_rw_empty", 32'(s_empty), 0);
    s_rd = 1'b1;
    tick();
    s_rd = 1'b0;
    chk("empty_rw_do",    32'(s_do),    32'h3C);
    chk("empty_rw_count0", 32'(s_count), 0);

    // 5. FWFT prefetch, full-rate pops and capacity.
    f_wr = 1'b1; f_di = 8'hA5;
    tick();
    f_wr = 1'b0;
    chk("fwft_n_empty", 32'(f_empty), 1);
    chk("fwft_n_count", 32'(f_count), 1);
    tick();
    chk("fwft_n1_do",    32'(f_do),    32'hA5);
    chk("fwft_n1_empty", 32'(f_empty), 0);
    f_wr = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      f_di = 8'(i);
      tick();
    end
    f_wr = 1'b0;
    chk("fwft_count4", 32'(f_count), 4);
    chk("fwft_head",   32'(f_do),    32'hA5);
    f_rd = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("fwft_pop_do_%0d", i),    32'(f_do),    32'(i));
      chk($sformatf("fwft_pop_count_%0d", i), 32'(f_count), 32'(4 - i));
    end
    tick();
    f_rd = 1'b0;
    chk("fwft_pop_empty", 32'(f_empty), 1);
    chk("fwft_pop_count", 32'(f_count), 0);
    // A pop while memory is empty, with a write in the same cycle.
    f_wr = 1'b1; f_di = 8'h5A;
    tick();
    f_wr = 1'b0;
    tick();
    chk("fwft_5a", 32'(f_do), 32'h5A);
    f_wr = 1'b1; f_rd = 1'b1; f_di = 8'h6B;
    tick();
    f_wr = 1'b0; f_rd = 1'b0;
    chk("fwft_popw_empty", 32'(f_empty), 1);
    chk("fwft_popw_count", 32'(f_count), 1);
    tick();
    chk("fwft_popw_do",    32'(f_do),    32'h6B);
    chk("fwft_popw_empty2", 32'(f_empty), 0);
    f_wr = 1'b1;
    for (int i = 0; i < 15; i++) begin
      f_di = 8'(8'h10 + i);
      tick();
    end
    chk("fwft_full",  32'(f_full),  1);
    chk("fwft_cnt16", 32'(f_count), 16);
    f_di = 8'hEE;
    tick();
    f_wr = 1'b0;
    chk("fwft_wrerr", 32'(f_wrerr), 1);
    chk("fwft_cnt16b", 32'(f_count), 16);
    chk("fwft_head6b", 32'(f_do), 32'h6B);
    f_rd = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk($sformatf("fwft_drain_do_%0d", i), 32'(f_do), 32'(8'h10 + i));
    end
    tick();
    f_rd = 1'b0;
    chk("fwft_drain_empty", 32'(f_empty), 1);
    chk("fwft_drain_count", 32'(f_count), 0);

    // 6. Asynchronous reset with data in flight.
    s_wr = 1'b1;
    for (int i = 0; i < 9; i++) begin
      s_di = 8'(8'h20 + i);
      tick();
    end
    s_wr = 1'b0;
    chk("pre_rst_count", 32'(s_count), 9);
    chk("pre_rst_do",    32'(s_do),    32'h3C);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_count", 32'(s_count), 0);
    chk("mid_rst_empty", 32'(s_empty), 1);
    chk("mid_rst_ae",    32'(s_ae),    1);
    chk("mid_rst_do",    32'(s_do),    0);
    chk("mid_rst_full",  32'(s_full),  0);
    #2 rst = 1'b0;
    tick();
    s_wr = 1'b1; s_di = 8'hC3;
    tick();
    s_wr = 1'b0;
    chk("post_rst_count", 32'(s_count), 1);
    s_rd = 1'b1;
    tick();
    s_rd = 1'b0;
    chk("post_rst_do",    32'(s_do),    32'hC3);
    chk("post_rst_empty", 32'(s_empty), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
